crop_window_ctrl: RTL
=====================

Name: crop_window_ctrl

Overview:
Frame-synchronous controller for the boundary-crop datapath. It measures the geometry of the incoming active video: line width in DE cycles and frame height in DE lines. It qualifies that geometry over consecutive frames, then computes the centred skip rows/columns from a host-programmed destination size. Crop parameters are applied only at frame boundaries, so the crop stage never sees a mid-frame window change. It sits beside the crop stage on the same pixel clock and taps the same vs/de stream.

Parameters:
CNT_BITS, 12, width of all geometry counters and outputs
MIN_DIM, 16, minimum accepted width and height; smaller measurements are treated as invalid

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  reset, asynchronous, active-high
vs_i  in  1  vertical sync, active-high
de_i  in  1  data enable; stable high for the whole active line
cfg_dst_w_i  in  CNT_BITS  destination (kept) width
cfg_dst_h_i  in  CNT_BITS  destination (kept) height
cfg_load_i  in  1  one-cycle strobe; latches cfg_dst_* into pending registers
total_cols_o  out  CNT_BITS  locked active width
total_rows_o  out  CNT_BITS  locked active height
skip_cols_o  out  CNT_BITS  columns blanked on each side
skip_rows_o  out  CNT_BITS  rows blanked top and bottom
crop_en_o  out  1  high when the parameters are valid for the current frame
locked_o  out  1  geometry qualified
geom_err_o  out  1  one-cycle pulse when the geometry changes while locked

Behaviour:
- Reset (async assert, synchronous release):
  - All outputs 0, state S_IDLE, all counters 0.
  - Pending cfg registers reset to 0, so skip is 0 until the first load.
- Edge detection:
  - vs_i and de_i are registered once.
  - vs_rise = vs_i & ~vs_q; de_fall = ~de_i & de_q.
- Width counter:
  - Increments while de_i is high and saturates at all-ones.
  - On de_fall: on the first line of the frame, the count is captured as line_w. On later lines, a mismatch with line_w sets a sticky bad flag for the frame.
- Height counter:
  - Increments on de_fall and saturates.
- On vs_rise:
  - The frame result is {line_w, height, ok}, where ok = ~bad & line_w>=MIN_DIM & height>=MIN_DIM.
  - Then the counters, bad flag and first-line flag clear.
- States, all transitions evaluated on vs_rise:
  - S_IDLE: go to S_MEAS. The partial frame before this is discarded.
  - S_MEAS: if ok, store the result as candidate and go to S_CHECK; else stay.
  - S_CHECK:
    - ok and equal to candidate: go to S_LOCK, load total_*_o, compute skip, set locked_o=1 and crop_en_o=1.
    - ok and not equal: replace candidate, stay.
    - not ok: go to S_MEAS.
  - S_LOCK:
    - ok and equal to the locked geometry: stay, and refresh skip from the pending cfg.
    - Otherwise: pulse geom_err_o; clear locked_o and crop_en_o; totals and skips hold their last value.
    - After a mismatch, go to S_CHECK with the new result as candidate if ok, else to S_MEAS.
- Skip arithmetic, width CNT_BITS, no wrap:
  - skip_cols = (dst_w >= total_w) ? 0 : (total_w - dst_w) >> 1. Odd differences floor.
  - skip_rows is the same using dst_h and total_h.
- Latency:
  - Outputs update on the clock edge after the edge where vs_i is first sampled high, i.e. 2 edges after vs_i rises.
  - Outputs are stable for the whole frame that follows.
- Configuration:
  - cfg_load_i writes the pending registers any time.
  - A value is used at the next vs_rise strictly after the load.
  - A load in the same cycle as vs_rise is applied at the following frame.
  - Back-to-back loads: the last one wins.
- Reset mid-frame: controller returns to S_IDLE. It needs 3 complete vs_rise events (IDLE→MEAS→CHECK→LOCK) to relock.
- vs_i held high across multiple cycles counts as one frame boundary.
- de_i high during vs_i is counted normally; no special handling.

Test Plan:
- Lock: reset, cfg load 640x480, send 4 frames of 800 DE × 600 lines.
  - locked_o=1 and crop_en_o=1 two edges after the 3rd vs_i rise.
  - total=800/600, skip_cols=80, skip_rows=60; nothing changes at the 4th rise.
- Config change while locked: load 700x500 mid-frame.
  - skip_cols/skip_rows stay 80/60 until the next vs_rise, then become 50/50.
  - A load coincident with vs_rise takes effect one frame later.
- Oversize and odd differences:
  - dst 1024x768 on an 800x600 source gives skip 0/0.
  - dst 641x481 gives skip_cols=79, skip_rows=59.
- Geometry change while locked: switch the source to 1280x720.
  - One geom_err_o pulse; locked_o=0 and crop_en_o=0.
  - Relock after one further matching frame with total=1280/720, skip 320/120 for a 640x480 dst.
- Unstable input, frame with one 799-DE line among 800-DE lines:
  - In S_CHECK the state returns to S_MEAS and no lock occurs.
  - Frames shorter than MIN_DIM lines never lock.
- Async reset asserted mid-line while locked: all outputs clear immediately (without a clock edge), and relock takes 3 vs_rise events after release.

Source files
------------

// File: rtl/crop_window_ctrl_if.sv
// Signal bundle between the crop controller and its environment: the tapped
// vs/de video stream, host crop configuration, and the locked crop parameters.
interface crop_window_ctrl_if #(
    parameter int CNT_BITS = 12
);
    logic                vs_i;
    logic                de_i;
    logic [CNT_BITS-1:0] cfg_dst_w_i;
    logic [CNT_BITS-1:0] cfg_dst_h_i;
    logic                cfg_load_i;
    logic [CNT_BITS-1:0] total_cols_o;
    logic [CNT_BITS-1:0] total_rows_o;
    logic [CNT_BITS-1:0] skip_cols_o;
    logic [CNT_BITS-1:0] skip_rows_o;
    logic                crop_en_o;
    logic                locked_o;
    logic                geom_err_o;

    // Video source / host side
    modport master (
        output vs_i, de_i, cfg_dst_w_i, cfg_dst_h_i, cfg_load_i,
        input  total_cols_o, total_rows_o, skip_cols_o, skip_rows_o,
               crop_en_o, locked_o, geom_err_o
    );

    // Controller side
    modport slave (
        input  vs_i, de_i, cfg_dst_w_i, cfg_dst_h_i, cfg_load_i,
        output total_cols_o, total_rows_o, skip_cols_o, skip_rows_o,
               crop_en_o, locked_o, geom_err_o
    );
endinterface

// File: rtl/crop_window_ctrl.sv
// Crop window controller: measures active-video width/height from vs/de,
// qualifies the geometry over consecutive frames, and publishes centred
// skip rows/columns for a host-programmed destination size. All published
// parameters change only at frame boundaries.
module crop_window_ctrl #(
    parameter int CNT_BITS = 12,
    parameter int MIN_DIM  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    crop_window_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_MEAS, S_CHECK, S_LOCK} state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] MIN_V   = CNT_BITS'(MIN_DIM);

    // Centred skip; an oversize destination keeps everything.
    function automatic logic [CNT_BITS-1:0] skip_calc(
        input logic [CNT_BITS-1:0] total,
        input logic [CNT_BITS-1:0] dst
    );
        if (dst >= total) begin
            return '0;
        end
        return (total - dst) >> 1;
    endfunction

    // Front-end measurement state
    logic                vs_q, de_q;
    logic [CNT_BITS-1:0] w_cnt_reg, h_cnt_reg, line_w_reg;
    logic                bad_reg, seen_line_reg;
    logic [CNT_BITS-1:0] pend_w_reg, pend_h_reg;
    logic [CNT_BITS-1:0] snap_w_reg, snap_h_reg;
    logic [CNT_BITS-1:0] res_w_reg, res_h_reg;
    logic                res_ok_reg, frame_done_reg;

    logic vs_rise, de_fall, frame_ok;
    assign vs_rise  = bus.vs_i & ~vs_q;
    assign de_fall  = ~bus.de_i & de_q;
    assign frame_ok = ~bad_reg & (line_w_reg >= MIN_V) & (h_cnt_reg >= MIN_V);

    // Host writes land in pending registers at any time; last write wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_w_reg <= '0;
            pend_h_reg <= '0;
        end else if (bus.cfg_load_i) begin
            pend_w_reg <= bus.cfg_dst_w_i;
            pend_h_reg <= bus.cfg_dst_h_i;
        end
    end

    // Line/frame measurement; at each frame boundary the result and the
    // pending cfg are snapshotted so the FSM acts on them one edge later.
    // The width counter is per-line (cleared whenever de is low), so it is
    // not touched at vs_rise and DE overlapping vs is counted normally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q           <= 1'b0;
            de_q           <= 1'b0;
            w_cnt_reg      <= '0;
            h_cnt_reg      <= '0;
            line_w_reg     <= '0;
            bad_reg        <= 1'b0;
            seen_line_reg  <= 1'b0;
            snap_w_reg     <= '0;
            snap_h_reg     <= '0;
            res_w_reg      <= '0;
            res_h_reg      <= '0;
            res_ok_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            vs_q           <= bus.vs_i;
            de_q           <= bus.de_i;
            frame_done_reg <= vs_rise;

            if (bus.de_i) begin
                if (w_cnt_reg != CNT_MAX) begin
                    w_cnt_reg <= w_cnt_reg + CNT_ONE;
                end
            end else begin
                w_cnt_reg <= '0;
            end

            if (vs_rise) begin
                res_w_reg     <= line_w_reg;
                res_h_reg     <= h_cnt_reg;
                res_ok_reg    <= frame_ok;
                snap_w_reg    <= pend_w_reg;
                snap_h_reg    <= pend_h_reg;
                h_cnt_reg     <= '0;
                line_w_reg    <= '0;
                bad_reg       <= 1'b0;
                seen_line_reg <= 1'b0;
            end else if (de_fall) begin
                if (h_cnt_reg != CNT_MAX) begin
                    h_cnt_reg <= h_cnt_reg + CNT_ONE;
                end
                if (!seen_line_reg) begin
                    line_w_reg    <= w_cnt_reg;
                    seen_line_reg <= 1'b1;
                end else if (w_cnt_reg != line_w_reg) begin
                    bad_reg <= 1'b1;
                end
            end
        end
    end

    // Skip values for the just-finished frame, one instance per axis
    // (index 0 = columns, 1 = rows).
    logic [1:0][CNT_BITS-1:0] res_dim, snap_dim, skip_val;
    assign res_dim  = {res_h_reg, res_w_reg};
    assign snap_dim = {snap_h_reg, snap_w_reg};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_skip
            assign skip_val[gi] = skip_calc(res_dim[gi], snap_dim[gi]);
        end
    endgenerate

    // Qualification FSM state and published parameters
    state_t              state_reg, state_next;
    logic [CNT_BITS-1:0] cand_w_reg, cand_w_next, cand_h_reg, cand_h_next;
    logic [CNT_BITS-1:0] tot_w_reg, tot_w_next, tot_h_reg, tot_h_next;
    logic [CNT_BITS-1:0] skip_c_reg, skip_c_next, skip_r_reg, skip_r_next;
    logic                locked_reg, locked_next, crop_en_reg, crop_en_next;
    logic                err_reg, err_next;

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            cand_w_reg  <= '0;
            cand_h_reg  <= '0;
            tot_w_reg   <= '0;
            tot_h_reg   <= '0;
            skip_c_reg  <= '0;
            skip_r_reg  <= '0;
            locked_reg  <= 1'b0;
            crop_en_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cand_w_reg  <= cand_w_next;
            cand_h_reg  <= cand_h_next;
            tot_w_reg   <= tot_w_next;
            tot_h_reg   <= tot_h_next;
            skip_c_reg  <= skip_c_next;
            skip_r_reg  <= skip_r_next;
            locked_reg  <= locked_next;
            crop_en_reg <= crop_en_next;
            err_reg     <= err_next;
        end
    end

    // Next-state/output logic; only acts the edge after a frame boundary.
    always_comb begin
        state_next   = state_reg;
        cand_w_next  = cand_w_reg;
        cand_h_next  = cand_h_reg;
        tot_w_next   = tot_w_reg;
        tot_h_next   = tot_h_reg;
        skip_c_next  = skip_c_reg;
        skip_r_next  = skip_r_reg;
        locked_next  = locked_reg;
        crop_en_next = crop_en_reg;
        err_next     = 1'b0;

        if (frame_done_reg) begin
            case (state_reg)
                S_IDLE: begin
                    // The partial frame seen since reset is discarded.
                    state_next = S_MEAS;
                end
                S_MEAS: begin
                    if (res_ok_reg) begin
                        cand_w_next = res_w_reg;
                        cand_h_next = res_h_reg;
                        state_next  = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (res_ok_reg && res_w_reg == cand_w_reg && res_h_reg == cand_h_reg) begin
                        state_next   = S_LOCK;
                        tot_w_next   = res_w_reg;
                        tot_h_next   = res_h_reg;
                        skip_c_next  = skip_val[0];
                        skip_r_next  = skip_val[1];
                        locked_next  = 1'b1;
                        crop_en_next = 1'b1;
                    end else if (res_ok_reg) begin
                        cand_w_next = res_w_reg;
                        cand_h_next = res_h_reg;
                    end else begin
                        state_next = S_MEAS;
                    end
                end
                S_LOCK: begin
                    if (res_ok_reg && res_w_reg == tot_w_reg && res_h_reg == tot_h_reg) begin
                        skip_c_next = skip_val[0];
                        skip_r_next = skip_val[1];
                    end else begin
                        // Totals and skips keep their last value for visibility.
                        err_next     = 1'b1;
                        locked_next  = 1'b0;
                        crop_en_next = 1'b0;
                        if (res_ok_reg) begin
                            cand_w_next = res_w_reg;
                            cand_h_next = res_h_reg;
                            state_next  = S_CHECK;
                        end else begin
                            state_next = S_MEAS;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign bus.total_cols_o = tot_w_reg;
    assign bus.total_rows_o = tot_h_reg;
    assign bus.skip_cols_o  = skip_c_reg;
    assign bus.skip_rows_o  = skip_r_reg;
    assign bus.crop_en_o    = crop_en_reg;
    assign bus.locked_o     = locked_reg;
    assign bus.geom_err_o   = err_reg;
endmodule
